// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decodes an instruction, drives the ALU, captures the result as a writeback record.
// Optional feature macro ALU_ISSUE_ADDU_EN adds ADDU/ADDIU decode with overflow ignored.
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] T1,
  output logic [31:0] T2,
  output logic [4:0]  shamt,
  output logic [3:0]  ALUOp,
  input  logic [31:0] alu_result,
  input  logic        alu_ov,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        exc_ov,
  output logic        exc_ill
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_NOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SLT = 4'b0111, OP_LUI = 4'b1000;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] t1_q, t1_d, t2_q, t2_d, wb_data_q, wb_data_d;
  logic [4:0]  shamt_q, shamt_d, wb_addr_q, wb_addr_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic        exc_ov_q, exc_ov_d, exc_ill_q, exc_ill_d;
  logic        ovchk_q, ovchk_d;

  logic [5:0]  opcode, funct;
  logic [31:0] imm_s, imm_z;
  logic [3:0]  dec_aluop;
  logic [31:0] dec_t2;
  logic [4:0]  dec_shamt, dec_dest;
  logic        dec_ill, dec_ovchk, ov_hit;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm_s  = {{16{instr[15]}}, instr[15:0]};
  assign imm_z  = {16'h0000, instr[15:0]};

  always_comb begin
    dec_aluop = OP_AND;
    dec_t2    = rt_val;
    dec_shamt = 5'd0;
    dec_dest  = instr[20:16];
    dec_ill   = 1'b0;
    dec_ovchk = 1'b0;
    if (opcode == 6'h00) begin
      dec_dest  = instr[15:11];
      dec_shamt = instr[10:6];
      case (funct)
        6'h24: dec_aluop = OP_AND;
        6'h25: dec_aluop = OP_OR;
        6'h20: begin dec_aluop = OP_ADD; dec_ovchk = 1'b1; end
        6'h27: dec_aluop = OP_NOR;
        6'h00: dec_aluop = OP_SLL;
        6'h02: dec_aluop = OP_SRL;
        6'h2A: dec_aluop = OP_SLT;
`ifdef ALU_ISSUE_ADDU_EN
        6'h21: dec_aluop = OP_ADD;
`endif
        default: dec_ill = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08: begin dec_aluop = OP_ADD; dec_t2 = imm_s; dec_ovchk = 1'b1; end
        6'h0C: begin dec_aluop = OP_AND; dec_t2 = imm_z; end
        6'h0D: begin dec_aluop = OP_OR;  dec_t2 = imm_z; end
        6'h0A: begin dec_aluop = OP_SLT; dec_t2 = imm_s; end
        6'h0F: begin dec_aluop = OP_LUI; dec_t2 = imm_z; end
`ifdef ALU_ISSUE_ADDU_EN
        6'h09: begin dec_aluop = OP_ADD; dec_t2 = imm_s; end
`endif
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Overflow only matters for the trapping adds; every other op ignores alu_ov.
  assign ov_hit = ovchk_q & alu_ov;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    shamt_d    = shamt_q;
    aluop_d    = aluop_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    exc_ov_d   = exc_ov_q;
    exc_ill_d  = exc_ill_q;
    ovchk_d    = ovchk_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          t1_d       = rs_val;
          t2_d       = dec_t2;
          shamt_d    = dec_shamt;
          aluop_d    = dec_aluop;
          wb_addr_d  = dec_dest;
          ovchk_d    = dec_ovchk;
          cnt_d      = CNT_INIT;
          in_ready_d = 1'b0;
          wb_we_d    = 1'b0;
          wb_data_d  = 32'd0;
          exc_ov_d   = 1'b0;
          exc_ill_d  = dec_ill;
          if (dec_ill) begin
            wb_valid_d = 1'b1;
            state_d    = RESP;
          end else begin
            state_d    = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          wb_data_d  = alu_result;
          exc_ov_d   = ov_hit;
          wb_we_d    = !ov_hit && (wb_addr_q != 5'd0);
          wb_valid_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      in_ready_q <= 1'b1;
      t1_q       <= 32'd0;
      t2_q       <= 32'd0;
      shamt_q    <= 5'd0;
      aluop_q    <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      exc_ov_q   <= 1'b0;
      exc_ill_q  <= 1'b0;
      ovchk_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      shamt_q    <= shamt_d;
      aluop_q    <= aluop_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      exc_ov_q   <= exc_ov_d;
      exc_ill_q  <= exc_ill_d;
      ovchk_q    <= ovchk_d;
    end
  end

  assign in_ready = in_ready_q;
  assign T1       = t1_q;
  assign T2       = t2_q;
  assign shamt    = shamt_q;
  assign ALUOp    = aluop_q;
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign exc_ov   = exc_ov_q;
  assign exc_ill  = exc_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl (SETTLE_CYCLES 1 and 3).
// Follows ALU_ISSUE_ADDU_EN when deciding whether ADDU/ADDIU are legal.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ov_force;
  logic [31:0] instr, rs_val, rt_val;
  logic        in_valid_a, in_valid_b, wb_ready_a, wb_ready_b;

  logic        in_ready_a, wb_valid_a, wb_we_a, exc_ov_a, exc_ill_a, alu_ov_a, ov_m_a;
  logic [31:0] T1_a, T2_a, wb_data_a, alu_result_a;
  logic [4:0]  shamt_a, wb_addr_a;
  logic [3:0]  ALUOp_a;

  logic        in_ready_b, wb_valid_b, wb_we_b, exc_ov_b, exc_ill_b, alu_ov_b;
  logic [31:0] T1_b, T2_b, wb_data_b, alu_result_b;
  logic [4:0]  shamt_b, wb_addr_b;
  logic [3:0]  ALUOp_b;

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [3:0] op);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0011: r = ~(a | b);
      4'b0100: r = b << sh;
      4'b0101: r = b >> sh;
      4'b0111: r = {31'd0, ($signed(a) < $signed(b))};
      4'b1000: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    return {ov, r};
  endfunction

  assign {ov_m_a, alu_result_a}   = alu_model(T1_a, T2_a, shamt_a, ALUOp_a);
  assign alu_ov_a                 = ov_m_a | ov_force;
  assign {alu_ov_b, alu_result_b} = alu_model(T1_b, T2_b, shamt_b, ALUOp_b);

  alu_issue_ctrl #(.SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .T1(T1_a), .T2(T2_a), .shamt(shamt_a), .ALUOp(ALUOp_a),
    .alu_result(alu_result_a), .alu_ov(alu_ov_a), .wb_valid(wb_valid_a), .wb_ready(wb_ready_a),
    .wb_we(wb_we_a), .wb_addr(wb_addr_a), .wb_data(wb_data_a), .exc_ov(exc_ov_a), .exc_ill(exc_ill_a)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .T1(T1_b), .T2(T2_b), .shamt(shamt_b), .ALUOp(ALUOp_b),
    .alu_result(alu_result_b), .alu_ov(alu_ov_b), .wb_valid(wb_valid_b), .wb_ready(wb_ready_b),
    .wb_we(wb_we_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b), .exc_ov(exc_ov_b), .exc_ill(exc_ill_b)
  );

  typedef struct {
    logic [3:0]  aluop;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [4:0]  sh;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        ov;
    logic        ill;
    int          lat;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic run_a(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input int hold, input rec_t e);
    rec_t g;
    int   k;
    @(negedge clk);
    instr = ins; rs_val = rs; rt_val = rt; in_valid_a = 1'b1;
    sb.push_back(e);
    chk({nm, ".in_ready_idle"}, 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wb_valid_a && k < 20);
    g = sb.pop_front();
    chk({nm, ".latency"}, 32'(k), 32'(g.lat));
    for (int i = 0; i < hold; i++) begin
      chk({nm, ".hold_valid"}, 32'(wb_valid_a), 32'd1);
      chk({nm, ".hold_data"}, wb_data_a, g.data);
      chk({nm, ".hold_in_ready"}, 32'(in_ready_a), 32'd0);
      @(negedge clk);
    end
    if (!g.ill) begin
      chk({nm, ".aluop"}, 32'(ALUOp_a), 32'(g.aluop));
      chk({nm, ".t1"}, T1_a, g.t1);
      chk({nm, ".t2"}, T2_a, g.t2);
      chk({nm, ".shamt"}, 32'(shamt_a), 32'(g.sh));
    end
    chk({nm, ".wb_addr"}, 32'(wb_addr_a), 32'(g.addr));
    chk({nm, ".wb_data"}, wb_data_a, g.data);
    chk({nm, ".wb_we"}, 32'(wb_we_a), 32'(g.we));
    chk({nm, ".exc_ov"}, 32'(exc_ov_a), 32'(g.ov));
    chk({nm, ".exc_ill"}, 32'(exc_ill_a), 32'(g.ill));
    wb_ready_a = 1'b1;
    @(posedge clk);
    #1 wb_ready_a = 1'b0;
    @(negedge clk);
    chk({nm, ".valid_drop"}, 32'(wb_valid_a), 32'd0);
    chk({nm, ".in_ready_back"}, 32'(in_ready_a), 32'd1);
  endtask

  logic saw_valid;
  int   k;
  rec_t g;

  initial begin
    rst = 1'b1; ov_force = 1'b0; instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; wb_ready_a = 1'b0; wb_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready_a), 32'd1);
    chk("reset.wb_valid", 32'(wb_valid_a), 32'd0);
    chk("reset.T1", T1_a, 32'd0);
    chk("reset.ALUOp", 32'(ALUOp_a), 32'd0);
    chk("reset.wb_data", wb_data_a, 32'd0);
    chk("reset.exc_ill", 32'(exc_ill_a), 32'd0);

    run_a("add",  rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 0,
          '{4'b0010, 32'd5, 32'd7, 5'd0, 5'd3, 32'd12, 1'b1, 1'b0, 1'b0, 2});
    run_a("addi_ov", itype(6'h08, 1, 2, 16'h0001), 32'h7FFFFFFF, 32'h12345678, 0,
          '{4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd2, 32'h80000000, 1'b0, 1'b1, 1'b0, 2});
    repeat (2) @(negedge clk);
    chk("addi_ov.once", 32'(wb_valid_a), 32'd0);
    run_a("lui_r0", itype(6'h0F, 0, 0, 16'hABCD), 32'h55, 32'h99, 0,
          '{4'b1000, 32'h55, 32'h0000ABCD, 5'd0, 5'd0, 32'hABCD0000, 1'b0, 1'b0, 1'b0, 2});
    run_a("sll_bp", rtype(0, 1, 4, 4, 6'h00), 32'd0, 32'd1, 5,
          '{4'b0100, 32'd0, 32'd1, 5'd4, 5'd4, 32'h10, 1'b1, 1'b0, 1'b0, 2});
    run_a("illegal", itype(6'h3F, 1, 9, 16'h1234), 32'd1, 32'd2, 0,
          '{4'b0000, 32'd0, 32'd0, 5'd0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1});
    ov_force = 1'b1;
    run_a("or_ov_ignored", rtype(1, 2, 5, 0, 6'h25), 32'hF0, 32'h0F, 0,
          '{4'b0001, 32'hF0, 32'h0F, 5'd0, 5'd5, 32'hFF, 1'b1, 1'b0, 1'b0, 2});
    ov_force = 1'b0;
    run_a("andi_zext", itype(6'h0C, 1, 7, 16'h8001), 32'hFFFFFFFF, 32'd0, 0,
          '{4'b0000, 32'hFFFFFFFF, 32'h00008001, 5'd0, 5'd7, 32'h8001, 1'b1, 1'b0, 1'b0, 2});
    run_a("slti_sext", itype(6'h0A, 1, 8, 16'hFFFF), 32'hFFFFFFFB, 32'd0, 0,
          '{4'b0111, 32'hFFFFFFFB, 32'hFFFFFFFF, 5'd0, 5'd8, 32'd1, 1'b1, 1'b0, 1'b0, 2});
    run_a("srl", rtype(1, 2, 10, 31, 6'h02), 32'd0, 32'h80000000, 0,
          '{4'b0101, 32'd0, 32'h80000000, 5'd31, 5'd10, 32'd1, 1'b1, 1'b0, 1'b0, 2});
    run_a("nor", rtype(1, 2, 11, 0, 6'h27), 32'd0, 32'd0, 0,
          '{4'b0011, 32'd0, 32'd0, 5'd0, 5'd11, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 2});
    run_a("slt", rtype(1, 2, 12, 0, 6'h2A), 32'd1, 32'hFFFFFFFF, 0,
          '{4'b0111, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd12, 32'd0, 1'b1, 1'b0, 1'b0, 2});
    run_a("ori_zext", itype(6'h0D, 1, 13, 16'h8000), 32'd1, 32'd0, 0,
          '{4'b0001, 32'd1, 32'h8000, 5'd0, 5'd13, 32'h8001, 1'b1, 1'b0, 1'b0, 2});
`ifdef ALU_ISSUE_ADDU_EN
    run_a("addu", rtype(1, 2, 6, 0, 6'h21), 32'h7FFFFFFF, 32'd1, 0,
          '{4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd6, 32'h80000000, 1'b1, 1'b0, 1'b0, 2});
    run_a("addiu", itype(6'h09, 1, 14, 16'hFFFF), 32'd5, 32'd0, 0,
          '{4'b0010, 32'd5, 32'hFFFFFFFF, 5'd0, 5'd14, 32'd4, 1'b1, 1'b0, 1'b0, 2});
`else
    run_a("addu", rtype(1, 2, 6, 0, 6'h21), 32'h7FFFFFFF, 32'd1, 0,
          '{4'b0000, 32'd0, 32'd0, 5'd0, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1});
    run_a("addiu", itype(6'h09, 1, 14, 16'hFFFF), 32'd5, 32'd0, 0,
          '{4'b0000, 32'd0, 32'd0, 5'd0, 5'd14, 32'd0, 1'b0, 1'b0, 1'b1, 1});
`endif

    // Three-cycle settle instance: latency check.
    @(negedge clk);
    instr = rtype(1, 2, 3, 0, 6'h20); rs_val = 32'd2; rt_val = 32'd3; in_valid_b = 1'b1;
    sb.push_back('{4'b0010, 32'd2, 32'd3, 5'd0, 5'd3, 32'd5, 1'b1, 1'b0, 1'b0, 4});
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wb_valid_b && k < 20);
    g = sb.pop_front();
    chk("settle3.latency", 32'(k), 32'(g.lat));
    chk("settle3.wb_data", wb_data_b, g.data);
    chk("settle3.wb_we", 32'(wb_we_b), 32'(g.we));
    wb_ready_b = 1'b1;
    @(posedge clk);
    #1 wb_ready_b = 1'b0;
    @(negedge clk);
    chk("settle3.valid_drop", 32'(wb_valid_b), 32'd0);

    // Reset while the instance is in DRIVE.
    @(negedge clk);
    instr = rtype(1, 2, 7, 0, 6'h20); rs_val = 32'd9; rt_val = 32'd9; in_valid_b = 1'b1;
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    @(negedge clk);
    chk("abort.T1_loaded", T1_b, 32'd9);
    chk("abort.in_ready_busy", 32'(in_ready_b), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.T1", T1_b, 32'd0);
    chk("abort.T2", T2_b, 32'd0);
    chk("abort.ALUOp", 32'(ALUOp_b), 32'd0);
    chk("abort.shamt", 32'(shamt_b), 32'd0);
    chk("abort.wb_addr", 32'(wb_addr_b), 32'd0);
    chk("abort.wb_data", wb_data_b, 32'd0);
    chk("abort.wb_valid", 32'(wb_valid_b), 32'd0);
    chk("abort.in_ready", 32'(in_ready_b), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | wb_valid_b;
    end
    chk("abort.no_record", 32'(saw_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand interface: accepts a decoded-stage instruction plus register operands and decodes opcode/funct into the 4-bit ALUOp encoding.
- Drives T1/T2/shamt/ALUOp into the ALU, waits a programmable settle time, then captures Result/OV.
- Presents a writeback or exception record to the register-file/exception logic over a valid/ready handshake.
- Sits between the register-read stage and the ALU in the simple MIPS datapath.

Parameters:
- SETTLE_CYCLES, 1, cycles ALU inputs are held stable before Result/OV are sampled (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  block can accept an instruction
- instr  in  32  instruction word
- rs_val  in  32  register rs value
- rt_val  in  32  register rt value
- T1  out  32  ALU operand 1
- T2  out  32  ALU operand 2
- shamt  out  5  ALU shift amount
- ALUOp  out  4  ALU operation code
- alu_result  in  32  ALU Result
- alu_ov  in  1  ALU OV
- wb_valid  out  1  result record valid
- wb_ready  in  1  consumer accepts record
- wb_we  out  1  register write enable (0 when dest=$0 or exception)
- wb_addr  out  5  destination register
- wb_data  out  32  write data
- exc_ov  out  1  record carries arithmetic overflow exception
- exc_ill  out  1  record carries illegal-instruction exception

Behaviour:
- Reset: state IDLE; in_ready=1 is not asserted during the reset cycle itself but is 1 the cycle after reset. T1, T2, wb_data=0; shamt, wb_addr=0; ALUOp=4'b0000; wb_valid, wb_we, exc_ov, exc_ill=0; settle counter=0. Reset mid-operation aborts the instruction; no record is emitted.
- ALUOp encoding: AND 0000, OR 0001, ADD 0010, NOR 0011, SLL 0100, SRL 0101, SLT 0111, LUI 1000.
- Decode for opcode 0 (R-type), using funct: 0x24 AND, 0x25 OR, 0x20 ADD, 0x27 NOR, 0x00 SLL, 0x02 SRL, 0x2A SLT. Destination is rd, T1=rs_val, T2=rt_val, shamt=instr[10:6].
- Decode for I-type, using opcode: 0x08 ADDI (T2=sign-ext imm), 0x0C ANDI (zero-ext), 0x0D ORI (zero-ext), 0x0A SLTI (sign-ext), 0x0F LUI (T2=zero-ext imm). Destination is rt, T1=rs_val, shamt=0.
- Any other opcode/funct is illegal.
- FSM:
  - IDLE: in_ready=1. On in_valid, register the decoded T1/T2/shamt/ALUOp/dest/illegal flag, load counter=SETTLE_CYCLES-1 and go to DRIVE. If the instruction is illegal, go directly to RESP with exc_ill=1, wb_we=0, wb_data=0.
  - DRIVE: ALU inputs are held constant and in_ready=0. Decrement the counter. When the counter is 0, sample alu_result/alu_ov and go to RESP.
  - RESP: wb_valid=1 and the record is held stable until wb_ready. Only when the cycle with wb_valid&wb_ready completes, return to IDLE. No back-to-back acceptance in the RESP exit cycle.
- Overflow: alu_ov is honoured only for ADD/ADDI. When set: exc_ov=1, wb_we=0, and wb_data holds alu_result as sampled. OV on other ops is ignored.
- wb_we=1 only when there is no exception and the destination is not 0. wb_addr always reports the decoded destination.
- Latency from in_valid accept to wb_valid: SETTLE_CYCLES+1 cycles, or 1 cycle for an illegal instruction.
- ALU outputs are level-held registers; they change only on accept in IDLE or on reset.

Optional Feature:
- Macro: ALU_ISSUE_ADDU_EN.
- When defined: R-type funct 0x21 (ADDU) and opcode 0x09 (ADDIU, sign-ext imm) decode to ALUOp 0010, and alu_ov is always ignored for them (exc_ov=0, normal writeback).
- When undefined: both encodings are illegal (exc_ill=1).

Test Plan:
- ADD rd=3: rs=5, rt=7, SETTLE_CYCLES=1, wb_ready=1 -> ALUOp=0010; wb_valid 2 cycles after accept; wb_data=12, wb_addr=3, wb_we=1.
- ADDI with overflow: rs=0x7FFFFFFF, imm=1, ALU model asserts OV -> exc_ov=1, wb_we=0, wb_valid once.
- LUI rt=$0, imm=0xABCD -> T2=0x0000ABCD, ALUOp=1000, wb_we=0 (dest $0), no exception.
- Backpressure: SLL rd=4, rt=1, shamt=4, wb_ready low 5 cycles -> wb_valid and wb_data=0x10 held stable; in_ready=0 until the handshake completes.
- Illegal: opcode 0x3F -> wb_valid the next cycle, exc_ill=1, wb_we=0. Also drive ADDU with and without ALU_ISSUE_ADDU_EN and check legal vs exc_ill.
- Reset during DRIVE with SETTLE_CYCLES=3 -> next cycle outputs are at reset values and no wb_valid is ever emitted for the aborted instruction.
